// File: rtl/lsu.sv
// RV32I load/store unit: one memory access per op over a req/ack bus,
// returning extended load data or store completion to writeback.
module lsu #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_is_store,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic [REGW-1:0] ex_rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [REGW-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_fault,
    output logic [XLEN-1:0] wb_fault_addr,
    output logic            stall
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] addr_q, wdata_q, data_q;
    logic [2:0]      funct3_q;
    logic            is_store_q, fault_q;
    logic [REGW-1:0] rd_q;
    logic [3:0]      strb_q;

    logic            acc_fault;
    logic [3:0]      st_strb;
    logic [XLEN-1:0] st_wdata, ld_shift, ld_data;

    // Legality and store lane steering for the op presented by execute.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        acc_fault = 1'b0;
        st_strb   = 4'b0000;
        st_wdata  = '0;
        if (ex_funct3 == 3'b011 || ex_funct3 == 3'b110 || ex_funct3 == 3'b111 ||
            (ex_is_store && ex_funct3 >= 3'b011))
            acc_fault = 1'b1;
        else if (ex_funct3[1:0] == 2'b01 && ex_addr[0])
            acc_fault = 1'b1;
        else if (ex_funct3[1:0] == 2'b10 && ex_addr[1:0] != 2'b00)
            acc_fault = 1'b1;
        case (ex_funct3[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << ex_addr[1:0];
                st_wdata = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                st_strb  = 4'b0011 << ex_addr[1:0];
                st_wdata = {2{ex_wdata[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = ex_wdata;
            end
        endcase
    end

    always_comb begin
        ld_shift = mem_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  ld_data = {24'h0, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b101:  ld_data = {16'h0, ld_shift[15:0]};
            default: ld_data = mem_rdata;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ex_valid) state_next = acc_fault ? DONE : REQ;
            REQ:     if (mem_ack)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            funct3_q   <= 3'b000;
            is_store_q <= 1'b0;
            fault_q    <= 1'b0;
            rd_q       <= '0;
            strb_q     <= 4'b0000;
        end else if (state == IDLE && ex_valid) begin
            addr_q     <= ex_addr;
            funct3_q   <= ex_funct3;
            is_store_q <= ex_is_store;
            fault_q    <= acc_fault;
            rd_q       <= ex_rd;
            data_q     <= '0;
            // Strobes and lane data stay zero for loads and faulting ops.
            strb_q     <= (ex_is_store && !acc_fault) ? st_strb : 4'b0000;
            wdata_q    <= (ex_is_store && !acc_fault) ? st_wdata : '0;
        end else if (state == REQ && mem_ack && !is_store_q) begin
            data_q     <= ld_data;
        end
    end

    always_comb begin
        ex_ready      = (state == IDLE);
        stall         = (state != IDLE);
        mem_req       = (state == REQ);
        mem_we        = (state == REQ) && is_store_q;
        mem_addr      = {addr_q[XLEN-1:2], 2'b00};
        mem_wstrb     = strb_q;
        mem_wdata     = wdata_q;
        wb_valid      = (state == DONE);
        wb_we         = (state == DONE) && !is_store_q && !fault_q && (rd_q != '0);
        wb_rd         = rd_q;
        wb_data       = data_q;
        wb_fault      = (state == DONE) && fault_q;
        wb_fault_addr = fault_q ? addr_q : '0;
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed table, reset-abort sequence and
// randomized ops checked against a behavioural model of RV32I memory ops.
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_ready, ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        wb_valid, wb_we, wb_fault, stall;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, wb_fault_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_store(ex_is_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_fault(wb_fault), .wb_fault_addr(wb_fault_addr), .stall(stall)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          dly;
        logic [3:0]  strb;
        logic [31:0] mwdata;
        logic        fault;
        logic [31:0] data;
        logic        we;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected results from the ISA rules: access size, alignment, lane placement.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          size;
        int          o;
        logic [31:0] mask, x;
        r = v;
        o = int'(v.addr % 32'd4);
        size = (v.f3 % 4 == 0) ? 1 : (v.f3 % 4 == 1) ? 2 : 4;
        r.fault = (v.f3 == 3'd3 || v.f3 >= 3'd6) || (v.st && v.f3 >= 3'd3) ||
                  (v.addr % 32'(size) != 0);
        r.strb = 4'h0; r.mwdata = 32'h0; r.data = 32'h0; r.we = 1'b0;
        if (!r.fault) begin
            if (v.st) begin
                r.strb = 4'(((1 << size) - 1) << o);
                for (int i = 0; i < 4; i++) r.mwdata[8*i +: 8] = v.wdata[8*(i % size) +: 8];
            end else begin
                mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
                x = (v.rdata >> (8 * o)) & mask;
                if (v.f3 < 3'd4 && size < 4 && x[8*size-1]) x = x | ~mask;
                r.data = x;
                r.we = (v.rd != 5'd0);
            end
        end
        return r;
    endfunction

    task automatic apply(input vec_t v);
        ex_valid = 1'b1; ex_is_store = v.st; ex_funct3 = v.f3;
        ex_addr = v.addr; ex_wdata = v.wdata; ex_rd = v.rd;
        check("ready_idle", 32'(ex_ready), 32'd1);
        check("stall_idle", 32'(stall), 32'd0);
        step();
        // Scramble execute inputs so only latched values can be correct.
        ex_valid = 1'b0; ex_addr = $urandom; ex_wdata = $urandom;
        ex_funct3 = 3'($urandom); ex_rd = 5'($urandom); ex_is_store = 1'($urandom);
        if (v.fault) begin
            check("fault_no_req", 32'(mem_req), 32'd0);
            check("fault_wb_valid", 32'(wb_valid), 32'd1);
            check("fault_flag", 32'(wb_fault), 32'd1);
            check("fault_addr", wb_fault_addr, v.addr);
            check("fault_wb_we", 32'(wb_we), 32'd0);
            check("fault_wb_data", wb_data, 32'h0);
            mem_ack = 1'b1;
        end else begin
            for (int i = 0; i <= v.dly; i++) begin
                check("req", 32'(mem_req), 32'd1);
                check("req_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
                check("req_we", 32'(mem_we), 32'(v.st));
                check("req_wstrb", 32'(mem_wstrb), 32'(v.strb));
                if (v.st) check("req_wdata", mem_wdata, v.mwdata);
                check("req_stall", 32'(stall), 32'd1);
                check("req_no_wb", 32'(wb_valid), 32'd0);
                if (i == v.dly) begin
                    mem_ack = 1'b1; mem_rdata = v.rdata;
                end else begin
                    mem_rdata = $urandom;
                end
                step();
                mem_ack = 1'b0;
            end
            check("done_req_drop", 32'(mem_req), 32'd0);
            check("done_wb_valid", 32'(wb_valid), 32'd1);
            check("done_fault", 32'(wb_fault), 32'd0);
            check("done_wb_data", wb_data, v.data);
            check("done_wb_we", 32'(wb_we), 32'(v.we));
            if (!v.st) check("done_wb_rd", 32'(wb_rd), 32'(v.rd));
            check("done_stall", 32'(stall), 32'd1);
            mem_rdata = $urandom;
        end
        step();
        mem_ack = 1'b0;
        check("after_wb_valid", 32'(wb_valid), 32'd0);
        check("after_ready", 32'(ex_ready), 32'd1);
        check("after_no_req", 32'(mem_req), 32'd0);
    endtask

    vec_t tbl[16];
    vec_t v;

    initial begin
        tbl[0]  = '{0, 3'b010, 32'h100,      32'h0,        5,  32'hDEADBEEF, 2, 4'h0,    32'h0,        0, 32'hDEADBEEF, 1};
        tbl[1]  = '{0, 3'b000, 32'h103,      32'h0,        6,  32'h80FF0000, 1, 4'h0,    32'h0,        0, 32'hFFFFFF80, 1};
        tbl[2]  = '{0, 3'b100, 32'h103,      32'h0,        7,  32'h80FF0000, 0, 4'h0,    32'h0,        0, 32'h00000080, 1};
        tbl[3]  = '{0, 3'b101, 32'h102,      32'h0,        8,  32'h80FF0000, 0, 4'h0,    32'h0,        0, 32'h000080FF, 1};
        tbl[4]  = '{1, 3'b000, 32'h201,      32'h12345678, 0,  32'h0,        0, 4'b0010, 32'h78787878, 0, 32'h0,        0};
        tbl[5]  = '{1, 3'b001, 32'h203,      32'h12345678, 3,  32'h0,        0, 4'h0,    32'h0,        1, 32'h0,        0};
        tbl[6]  = '{0, 3'b010, 32'h102,      32'h0,        4,  32'h0,        0, 4'h0,    32'h0,        1, 32'h0,        0};
        tbl[7]  = '{0, 3'b011, 32'h100,      32'h0,        4,  32'h0,        0, 4'h0,    32'h0,        1, 32'h0,        0};
        tbl[8]  = '{0, 3'b010, 32'h104,      32'h0,        0,  32'hCAFEF00D, 1, 4'h0,    32'h0,        0, 32'hCAFEF00D, 0};
        tbl[9]  = '{1, 3'b010, 32'h300,      32'hA5A55A5A, 9,  32'h0,        3, 4'hF,    32'hA5A55A5A, 0, 32'h0,        0};
        tbl[10] = '{1, 3'b001, 32'h202,      32'hCAFEBABE, 1,  32'h0,        0, 4'b1100, 32'hBABEBABE, 0, 32'h0,        0};
        tbl[11] = '{0, 3'b001, 32'h100,      32'h0,        2,  32'h12348001, 0, 4'h0,    32'h0,        0, 32'hFFFF8001, 1};
        tbl[12] = '{0, 3'b010, 32'hFFFFFFFC, 32'h0,        31, 32'h01020304, 0, 4'h0,    32'h0,        0, 32'h01020304, 1};
        tbl[13] = '{1, 3'b100, 32'h400,      32'h1,        1,  32'h0,        0, 4'h0,    32'h0,        1, 32'h0,        0};
        tbl[14] = '{0, 3'b110, 32'h400,      32'h0,        1,  32'h0,        0, 4'h0,    32'h0,        1, 32'h0,        0};
        tbl[15] = '{0, 3'b000, 32'h101,      32'h0,        3,  32'h00007F00, 0, 4'h0,    32'h0,        0, 32'h0000007F, 1};

        reset = 1'b1; ex_valid = 1'b0; ex_is_store = 1'b0; ex_funct3 = 3'b000;
        ex_addr = '0; ex_wdata = '0; ex_rd = '0; mem_ack = 1'b0; mem_rdata = '0;
        step(); step();
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_we", 32'(wb_we), 32'd0);
        check("rst_fault", 32'(wb_fault), 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wstrb", 32'(mem_wstrb), 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_fault_addr", wb_fault_addr, 32'h0);
        check("rst_ready", 32'(ex_ready), 32'd1);
        reset = 1'b0;
        step();

        for (int i = 0; i < 16; i++) apply(tbl[i]);

        // Reset lands while the bus request is outstanding; the late ack must vanish.
        ex_valid = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b010;
        ex_addr = 32'h500; ex_rd = 5'd5;
        step();
        ex_valid = 1'b0;
        check("abort_req", 32'(mem_req), 32'd1);
        step();
        reset = 1'b1;
        step();
        check("abort_req_drop", 32'(mem_req), 32'd0);
        check("abort_ready", 32'(ex_ready), 32'd1);
        check("abort_no_wb", 32'(wb_valid), 32'd0);
        check("abort_wstrb", 32'(mem_wstrb), 32'h0);
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
        step();
        mem_ack = 1'b0;
        check("late_ack_no_wb", 32'(wb_valid), 32'd0);
        check("late_ack_no_req", 32'(mem_req), 32'd0);
        check("late_ack_ready", 32'(ex_ready), 32'd1);
        step();
        check("late_ack_no_wb2", 32'(wb_valid), 32'd0);

        for (int n = 0; n < 60; n++) begin
            v.st = 1'($urandom_range(0, 1));
            v.f3 = 3'($urandom_range(0, 7));
            v.addr = $urandom; v.wdata = $urandom; v.rdata = $urandom;
            v.rd = 5'($urandom_range(0, 31));
            v.dly = $urandom_range(0, 3);
            v = model(v);
            apply(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit directly downstream of the execute-stage ALU.
- Takes the ALU result as the effective address, plus store data and funct3 from decode.
- Performs one RV32I memory access per instruction over a req/ack data-memory handshake.
- Returns aligned, sign- or zero-extended load data (or store completion) to writeback, stalling the pipeline while the access is outstanding.

Parameters:
- XLEN, 32, data/address width (only 32 supported)
- REGW, 5, destination register index width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  execute stage presents a memory op this cycle
- ex_ready  out  1  LSU can accept an op (1 only in IDLE)
- ex_is_store  in  1  1 = store, 0 = load
- ex_funct3  in  3  RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- ex_addr  in  32  effective address (ALU result)
- ex_wdata  in  32  store data (rs2)
- ex_rd  in  5  load destination register
- mem_req  out  1  bus request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables (0000 for loads)
- mem_ack  in  1  access complete; mem_rdata valid this cycle for loads
- mem_rdata  in  32  read word
- wb_valid  out  1  one-cycle completion pulse
- wb_we  out  1  1 = write wb_data to wb_rd (loads only, rd≠0)
- wb_rd  out  5  destination register
- wb_data  out  32  extended load data
- wb_fault  out  1  misaligned or illegal access (qualifies wb_valid)
- wb_fault_addr  out  32  offending ex_addr
- stall  out  1  ~ex_ready, to hazard unit

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - mem_req, mem_we, wb_valid, wb_we, wb_fault = 0; all data/address/strobe outputs = 0.
  - ex_ready = 1 from the first cycle after reset.
  - Reset mid-access drops mem_req in the next cycle; a late mem_ack is ignored.
- States: IDLE, REQ, DONE.
- IDLE:
  - On ex_valid, latch addr/wdata/funct3/is_store/rd.
  - Check legality:
    - funct3 ∈ {011,110,111} is illegal, as is any store funct3 ≥ 011.
    - Misaligned: H with addr[0]=1, or W with addr[1:0]≠00.
  - Illegal or misaligned → DONE with wb_fault=1, wb_fault_addr=addr, wb_we=0, no bus cycle.
  - Otherwise → REQ.
- REQ:
  - mem_req=1 with mem_addr, mem_we, mem_wstrb, mem_wdata stable every cycle until mem_ack.
  - mem_ack may arrive in the first REQ cycle.
  - On mem_ack:
    - Loads capture extracted data; stores capture nothing.
    - Go to DONE; mem_req=0 in the next cycle.
  - mem_ack outside REQ is ignored.
- DONE:
  - wb_valid=1 for exactly one cycle, then IDLE.
  - wb_we = load & ~fault & (rd≠0).
- Latency: accept in cycle N, mem_req from N+1, ack in cycle M ≥ N+1, wb_valid in M+1. Fault: wb_valid in N+1.
- Throughput: a new op is accepted in the cycle after DONE.
- Store lanes, with o = addr[1:0]:
  - SB: wstrb = 0001<<o, wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 0011<<o, wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111, wdata = wdata.
- Load extract:
  - sh = rdata >> (8*o).
  - LB: sign-extend sh[7:0]; LBU: zero-extend sh[7:0].
  - LH: sign-extend sh[15:0]; LHU: zero-extend sh[15:0].
  - LW: rdata.
- wb_data = 0 for stores and faults.
- Address wrap-around is not checked: 0xFFFFFFFC with LW is legal.

Test Plan:
- LW addr 0x100, mem_rdata=0xDEADBEEF, ack after 3 REQ cycles -> mem_addr 0x100, wstrb 0000, req held 3 cycles, wb_valid 1 cycle after ack, wb_data 0xDEADBEEF, wb_we=1.
- LB addr 0x103, rdata 0x80FF_0000 -> wb_data 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
- SB addr 0x201, wdata 0x12345678, same-cycle ack -> mem_addr 0x200, wstrb 0010, mem_wdata 0x78787878, wb_valid with wb_we=0.
- SH addr 0x203 -> no mem_req, wb_valid+wb_fault next cycle, wb_fault_addr 0x203; also LW addr 0x102 faults identically; funct3 011 faults.
- Reset asserted during REQ, then mem_ack one cycle later -> mem_req 0 after reset edge, no wb_valid, ex_ready 1.
- LW with ex_rd=0 -> access performed, wb_valid=1, wb_we=0; back-to-back ops -> second accepted in the cycle after first DONE, stall=1 throughout REQ/DONE.
